// File: rtl/cordic_iter_core.sv
// Iterative circular CORDIC engine, one micro-rotation per clock.
// Rotation and vectoring modes; CORDIC gain is left uncompensated.
module cordic_iter_core #(
    parameter int Width = 16,
    parameter int Iter  = 14
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    mode_i,
    input  logic signed [Width-1:0] x_i,
    input  logic signed [Width-1:0] y_i,
    input  logic signed [Width-1:0] z_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [Width-1:0] x_o,
    output logic signed [Width-1:0] y_o,
    output logic signed [Width-1:0] z_o
);

    localparam int XW = Width + 2;
    localparam int CW = $clog2(Iter + 1);

    if (Iter < 1 || Iter > Width - 1) begin : g_bad_iter
        $error("cordic_iter_core: Iter must be 1..Width-1");
    end

    function automatic logic [Iter*Width-1:0] build_rom();
        logic [Iter*Width-1:0] rom;
        real a;
        real scale;
        rom   = '0;
        scale = 1.0;
        for (int k = 0; k < Width - 3; k++) scale = scale * 2.0;
        for (int i = 0; i < Iter; i++) begin
            case (i)
                0:  a = 0.7853981633974483;
                1:  a = 0.4636476090008061;
                2:  a = 0.24497866312686414;
                3:  a = 0.12435499454676144;
                4:  a = 0.06241880999595735;
                5:  a = 0.031239833430268277;
                6:  a = 0.015623728620476831;
                7:  a = 0.007812341060101111;
                8:  a = 0.0039062301319669718;
                9:  a = 0.0019531225164788188;
                10: a = 0.0009765621895593195;
                11: a = 0.0004882812111948983;
                12: a = 0.00024414062014936177;
                13: a = 0.00012207031189367021;
                14: a = 0.00006103515617420877;
                default: begin
                    // atan(2^-i) == 2^-i well below 1 LSB here
                    a = 1.0;
                    for (int k = 0; k < i; k++) a = a / 2.0;
                end
            endcase
            rom[i*Width +: Width] = Width'($rtoi(a * scale + 0.5));
        end
        return rom;
    endfunction

    localparam logic [Iter*Width-1:0] ATAN_ROM = build_rom();

    function automatic logic signed [Width-1:0] sat(
        input logic signed [XW-1:0] v
    );
        if ((&v[XW-1:Width-1]) || !(|v[XW-1:Width-1]))
            return v[Width-1:0];
        else if (v[XW-1])
            return {1'b1, {(Width-1){1'b0}}};
        else
            return {1'b0, {(Width-1){1'b1}}};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic signed [XW-1:0]    x_q, y_q;
    logic signed [XW-1:0]    x_sh, y_sh;
    logic signed [XW-1:0]    x_nx, y_nx;
    logic signed [Width-1:0] z_q, z_nx, atan;
    logic                    mode_q, d;
    logic [CW-1:0]           cnt;

    always_comb begin
        x_sh = x_q >>> cnt;
        y_sh = y_q >>> cnt;
        atan = ATAN_ROM[int'(cnt)*Width +: Width];
        // d=1 means "angle negative": rotate clockwise, add atan
        d    = mode_q ? ~y_q[XW-1] : z_q[Width-1];
        if (d) begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + atan;
        end else begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - atan;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            z_o         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            mode_q      <= 1'b0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        x_q        <= {{2{x_i[Width-1]}}, x_i};
                        y_q        <= {{2{y_i[Width-1]}}, y_i};
                        z_q        <= z_i;
                        mode_q     <= mode_i;
                        cnt        <= '0;
                        in_ready_o <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    x_q <= x_nx;
                    y_q <= y_nx;
                    z_q <= z_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(Iter - 1)) begin
                        x_o         <= sat(x_nx);
                        y_o         <= sat(y_nx);
                        z_o         <= z_nx;
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed bench for cordic_iter_core (Width=16, Iter=14).
// Results compared against ideal CORDIC math within tolerance.
module tb_cordic_iter_core;

    localparam int W = 16;
    localparam int N = 14;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                mode = 1'b0;
    logic signed [W-1:0] x_in = '0;
    logic signed [W-1:0] y_in = '0;
    logic signed [W-1:0] z_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] x_out, y_out, z_out;

    int errors = 0;
    int checks = 0;

    cordic_iter_core #(.Width(W), .Iter(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .mode_i     (mode),
        .x_i        (x_in),
        .y_i        (y_in),
        .z_i        (z_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .x_o        (x_out),
        .y_o        (y_out),
        .z_o        (z_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic m;
        int   x, y, z;
        int   ex, ey, ez;
        int   tx, ty, tz;
    } vec_t;

    task automatic chk(input string name, input int got,
                       input int exp, input int tol);
        checks++;
        if (got - exp > tol || exp - got > tol) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (tol %0d)",
                     name, got, exp, tol);
        end
    endtask

    task automatic run_op(input logic m, input int xi, input int yi,
                          input int zi, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", int'(in_ready), 1, 0);
        mode     = m;
        x_in     = 16'(xi);
        y_in     = 16'(yi);
        z_in     = 16'(zi);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_valid", int'(out_valid), 0, 0);
        chk("idle_ready", int'(in_ready), 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   lat;
        int   seen;

        vecs[0]  = '{1'b0, 10000, 0, 0, 16468, 0, 0, 16, 16, 8};
        vecs[1]  = '{1'b0, 10000, 0, 12868, 0, 16468, 0, 16, 16, 8};
        vecs[2]  = '{1'b0, 10000, 0, -12868, 0, -16468, 0, 16, 16, 8};
        vecs[3]  = '{1'b0, 10000, 0, 6434, 11645, 11645, 0, 16, 16, 8};
        vecs[4]  = '{1'b1, 10000, 10000, 0, 23289, 0, 6434, 16, 16, 8};
        vecs[5]  = '{1'b1, 10000, -10000, 0, 23289, 0, -6434, 16, 16, 8};
        vecs[6]  = '{1'b1, 20000, 0, 1000, 32767, 0, 1000, 0, 16, 8};
        vecs[7]  = '{1'b0, 30000, 0, 0, 32767, 0, 0, 0, 16, 8};
        vecs[8]  = '{1'b0, -30000, 0, 0, -32768, 0, 0, 0, 16, 8};
        vecs[9]  = '{1'b0, 0, -30000, 0, 0, -32768, 0, 16, 0, 8};
        vecs[10] = '{1'b1, 3000, 4000, 0, 8234, 0, 7596, 16, 16, 8};

        // reset state, asserted asynchronously
        #2;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_x", int'(x_out), 0, 0);
        chk("rst_y", int'(y_out), 0, 0);
        chk("rst_z", int'(z_out), 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].z, lat);
            chk($sformatf("v%0d_latency", i), lat, N, 0);
            chk($sformatf("v%0d_x", i), int'(x_out), vecs[i].ex,
                vecs[i].tx);
            chk($sformatf("v%0d_y", i), int'(y_out), vecs[i].ey,
                vecs[i].ty);
            chk($sformatf("v%0d_z", i), int'(z_out), vecs[i].ez,
                vecs[i].tz);
            release_out();
        end

        // output stall with in_valid pulses that must be ignored
        run_op(1'b0, 10000, 0, 0, lat);
        chk("stall_latency", lat, N, 0);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            x_in     = 16'(1234 + i);
            y_in     = 16'(-500);
            z_in     = 16'(3000);
            mode     = 1'b1;
            @(posedge clk);
            #1;
            chk("stall_valid", int'(out_valid), 1, 0);
            chk("stall_ready", int'(in_ready), 0, 0);
            chk("stall_x", int'(x_out), 16468, 16);
            chk("stall_y", int'(y_out), 0, 16);
            chk("stall_z", int'(z_out), 0, 8);
        end
        in_valid = 1'b0;
        release_out();
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("stall_no_extra_op", seen, 0, 0);

        // abort mid-operation at cnt=5
        run_op(1'b1, 3000, 4000, 0, lat);
        release_out();
        @(negedge clk);
        mode     = 1'b0;
        x_in     = 16'(10000);
        y_in     = 16'(0);
        z_in     = 16'(12868);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1, 0);
        chk("abort_out_valid", int'(out_valid), 0, 0);
        chk("abort_x", int'(x_out), 0, 0);
        chk("abort_y", int'(y_out), 0, 0);
        chk("abort_z", int'(z_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0, 0);

        run_op(1'b0, 10000, 0, 12868, lat);
        chk("post_abort_latency", lat, N, 0);
        chk("post_abort_x", int'(x_out), 0, 16);
        chk("post_abort_y", int'(y_out), 16468, 16);
        chk("post_abort_z", int'(z_out), 0, 8);
        release_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
